shift_normalizer_seq: RTL

Iterative normalizer that undoes a barrel shift. It takes a word, shifts it one bit per cycle until the target end bit (MSB or LSB) is set, and reports the normalized word and the shift count.
Shifting out_data by out_shift in the opposite direction, with zero fill, restores in_data exactly.
It feeds normalized operands and shift amounts back to the barrel-shift datapath.
It uses valid/ready handshakes on both sides.

---
 rtl/shift_normalizer_seq_pkg.sv | 22 ++
 rtl/shift_normalizer_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/shift_normalizer_seq_pkg.sv
// Shared definitions for the iterative shift normalizer.
//   state_t    : FSM states (IDLE / SHIFT / DONE)
//   DIR_LEFT   : normalize toward the MSB (left shifts)
//   DIR_RIGHT  : normalize toward the LSB (right shifts)
//   cw_of()    : shift-count width able to hold WIDTH-1
package shift_normalizer_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Largest count needed is WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cw_of(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_normalizer_seq.sv
// Iterative normalizer: shifts a captured word one bit per cycle toward the
// selected end until the end bit is set, then presents the normalized word
// and the number of shifts applied. Shifting out_data back by out_shift in
// the opposite direction with zero fill restores the original word.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and ready never depends on valid.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready only in IDLE and not in reset
//   in_data         word to normalize (sampled only at the accept edge)
//   in_dir          0 = toward MSB, 1 = toward LSB (sampled at accept edge)
//   out_valid/ready downstream handshake; out_valid high only in DONE
//   out_data        normalized word
//   out_shift       number of single-bit shifts applied
//   out_zero        the captured word was all zeros
module shift_normalizer_seq
  import shift_normalizer_seq_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_shift,
  output logic             out_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dir_q,   dir_d;
  logic [CW-1:0]    shift_q, shift_d;
  logic             zero_q,  zero_d;
  logic             target_bit;

  assign target_bit = (dir_q == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          dir_d   = in_dir;
          shift_d = '0;
          zero_d  = (in_data == '0);
          // A zero word also takes one evaluation cycle in SHIFT, so every
          // result arrives shift_count+1 edges after the accept edge.
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (zero_q || target_bit) begin
          state_d = ST_DONE;
        end else begin
          data_d  = (dir_q == DIR_RIGHT) ? (data_q >> 1) : (data_q << 1);
          shift_d = shift_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;

endmodule
